// File: rtl/ble_tx_pkg.sv
// BLE GFSK transmitter shared types and tables.
// FSM states, Gaussian phase weights and quarter-wave sine.
package ble_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DRAIN
  } tx_state_e;

  localparam int PIPE_LAT = 2;

  // Per-sample weights for prev/cur/next symbol; each column sums to 4
  localparam logic [15:0][2:0] W0_TAB = {{14{3'd0}}, 3'd1, 3'd1};
  localparam logic [15:0][2:0] W1_TAB = {3'd3, 3'd3, {12{3'd4}}, 3'd3, 3'd3};
  localparam logic [15:0][2:0] W2_TAB = {3'd1, 3'd1, {14{3'd0}}};

  // round(7*sin(k*pi/128)) for k=0..64, held as step breakpoints
  function automatic logic [2:0] qsin(input logic [6:0] k);
    if (k >= 7'd49) return 3'd7;
    else if (k >= 7'd37) return 3'd6;
    else if (k >= 7'd29) return 3'd5;
    else if (k >= 7'd22) return 3'd4;
    else if (k >= 7'd15) return 3'd3;
    else if (k >= 7'd9) return 3'd2;
    else if (k >= 7'd3) return 3'd1;
    else return 3'd0;
  endfunction

endpackage

// File: rtl/gfsk_trig_lut.sv
// Registered phase -> (cos, sin) lookup.
// Quadrant folding over a quarter-wave sine table.
module gfsk_trig_lut
  import ble_tx_pkg::*;
#(
  parameter int PHASE_WIDTH = 8,
  parameter int DATA_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         en,
  input  logic                         valid,
  input  logic [PHASE_WIDTH-1:0]       phase,
  output logic signed [DATA_WIDTH-1:0] cos_val,
  output logic signed [DATA_WIDTH-1:0] sin_val
);

  logic [1:0] quad;
  logic [6:0] off;
  logic [6:0] off_c;
  logic signed [DATA_WIDTH-1:0] ma;
  logic signed [DATA_WIDTH-1:0] mb;
  logic signed [DATA_WIDTH-1:0] c;
  logic signed [DATA_WIDTH-1:0] s;

  always_comb begin
    quad  = phase[PHASE_WIDTH-1 -: 2];
    off   = {1'b0, phase[PHASE_WIDTH-3:0]};
    off_c = 7'd64 - off;
    ma    = DATA_WIDTH'(qsin(off));
    mb    = DATA_WIDTH'(qsin(off_c));
    c     = mb;
    s     = ma;
    unique case (quad)
      2'd0: begin c = mb;  s = ma;  end
      2'd1: begin c = -ma; s = mb;  end
      2'd2: begin c = -mb; s = -ma; end
      2'd3: begin c = ma;  s = -mb; end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cos_val <= '0;
      sin_val <= '0;
    end else if (en) begin
      cos_val <= valid ? c : '0;
      sin_val <= valid ? s : '0;
    end
  end

endmodule

// File: rtl/ble_gfsk_modulator.sv
// BLE GFSK baseband modulator: bit stream in, I/Q samples out.
// Three-symbol Gaussian phase shaping feeding a trig lookup.
module ble_gfsk_modulator
  import ble_tx_pkg::*;
#(
  parameter int SAMPLE_RATE = 16,
  parameter int DATA_WIDTH  = 4,
  parameter int PHASE_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         en,
  input  logic                         bit_valid,
  input  logic                         bit_data,
  input  logic                         bit_last,
  output logic                         bit_ready,
  output logic signed [DATA_WIDTH-1:0] i_data,
  output logic signed [DATA_WIDTH-1:0] q_data,
  output logic                         sample_valid,
  output logic                         symbol_clk,
  output logic                         busy,
  output logic                         underrun
);

  localparam int IW = $clog2(SAMPLE_RATE);
  localparam logic [IW-1:0] IDX_LAST = IW'(SAMPLE_RATE - 1);
  localparam logic [1:0] DRAIN_END = 2'(PIPE_LAT - 1);

  tx_state_e state;
  tx_state_e state_n;

  logic prev;
  logic cur;
  logic nxt;
  logic last_taken;
  logic final_sym;
  logic [IW-1:0] idx;
  logic [PHASE_WIDTH-1:0] phase;
  logic [PHASE_WIDTH-1:0] p1;
  logic v1;
  logic s1;
  logic [1:0] drain_cnt;
  logic take;
  logic wrap;
  logic signed [PHASE_WIDTH-1:0] step;

  function automatic logic signed [PHASE_WIDTH-1:0] term(
    input logic b,
    input logic [2:0] w
  );
    return b ? PHASE_WIDTH'(w) : -PHASE_WIDTH'(w);
  endfunction

  always_comb begin
    step = term(prev, W0_TAB[idx])
         + term(cur, W1_TAB[idx])
         + term(nxt, W2_TAB[idx]);
  end

  always_comb begin
    state_n   = state;
    bit_ready = 1'b0;
    unique case (state)
      IDLE, PRIME: bit_ready = resetn;
      RUN:         bit_ready = (idx == IDX_LAST) && !last_taken;
      default:     bit_ready = 1'b0;
    endcase
    take = en && bit_valid && bit_ready;
    wrap = en && (state == RUN) && (idx == IDX_LAST);
    if (en) begin
      unique case (state)
        IDLE:  if (take) state_n = bit_last ? RUN : PRIME;
        PRIME: if (take) state_n = RUN;
        RUN:   if (wrap && final_sym) state_n = DRAIN;
        DRAIN: if (drain_cnt == DRAIN_END) state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      prev       <= 1'b0;
      cur        <= 1'b0;
      nxt        <= 1'b0;
      last_taken <= 1'b0;
      final_sym  <= 1'b0;
      idx        <= '0;
      phase      <= '0;
      p1         <= '0;
      v1         <= 1'b0;
      s1         <= 1'b0;
      drain_cnt  <= '0;
      underrun   <= 1'b0;
    end else if (en) begin
      state <= state_n;
      v1    <= 1'b0;
      s1    <= 1'b0;
      unique case (state)
        IDLE: if (take) begin
          prev       <= bit_data;
          cur        <= bit_data;
          nxt        <= bit_data;
          last_taken <= bit_last;
          final_sym  <= bit_last;
          phase      <= '0;
          idx        <= '0;
          underrun   <= 1'b0;
          drain_cnt  <= '0;
        end
        PRIME: if (take) begin
          nxt        <= bit_data;
          last_taken <= bit_last;
        end
        RUN: begin
          v1    <= 1'b1;
          s1    <= (idx == '0);
          p1    <= phase;
          phase <= phase + step;
          idx   <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            prev      <= cur;
            cur       <= nxt;
            drain_cnt <= '0;
            if (take) begin
              nxt        <= bit_data;
              last_taken <= bit_last;
            end else begin
              // no further bit: symbol now starting closes the packet
              last_taken <= 1'b1;
              final_sym  <= 1'b1;
              if (!last_taken) underrun <= 1'b1;
            end
          end
        end
        DRAIN: drain_cnt <= drain_cnt + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sample_valid <= 1'b0;
      symbol_clk   <= 1'b0;
    end else if (en) begin
      sample_valid <= v1;
      symbol_clk   <= s1;
    end
  end

  gfsk_trig_lut #(
    .PHASE_WIDTH(PHASE_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lut (
    .clk    (clk),
    .resetn (resetn),
    .en     (en),
    .valid  (v1),
    .phase  (p1),
    .cos_val(i_data),
    .sin_val(q_data)
  );

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ble_gfsk_modulator.sv
// Self-checking bench for ble_gfsk_modulator.
// Real-valued trig model of the shaped phase trajectory.
module tb_ble_gfsk_modulator;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic en = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_data = 1'b0;
  logic bit_last = 1'b0;
  logic bit_ready;
  logic sample_valid;
  logic symbol_clk;
  logic busy;
  logic underrun;
  logic signed [3:0] i_data;
  logic signed [3:0] q_data;

  int total = 0;
  int bad = 0;

  int W0[16] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int W1[16] = '{3, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 3, 3};
  int W2[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

  int exp_i[$];
  int exp_q[$];
  int exp_s[$];
  int cap_i[$];
  int cap_q[$];
  int nvalid = 0;
  int npulse = 0;
  bit en_s = 1'b0;
  bit prev_v = 1'b0;
  bit pk[$];

  always #5 clk = ~clk;

  ble_gfsk_modulator dut (
    .clk         (clk),
    .resetn      (resetn),
    .en          (en),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .bit_last    (bit_last),
    .bit_ready   (bit_ready),
    .i_data      (i_data),
    .q_data      (q_data),
    .sample_valid(sample_valid),
    .symbol_clk  (symbol_clk),
    .busy        (busy),
    .underrun    (underrun)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // One symbol per bit; edges reuse the first/last bit as neighbour
  task automatic model(input bit b[$]);
    int n;
    int ph;
    n = b.size();
    ph = 0;
    for (int k = 0; k < n; k++) begin
      int sp;
      int sc;
      int sn;
      sp = b[(k == 0) ? 0 : k - 1] ? 1 : -1;
      sc = b[k] ? 1 : -1;
      sn = b[(k == n - 1) ? k : k + 1] ? 1 : -1;
      for (int j = 0; j < 16; j++) begin
        real a;
        a = 6.283185307179586 * real'(ph) / 256.0;
        exp_i.push_back(rnd(7.0 * $cos(a)));
        exp_q.push_back(rnd(7.0 * $sin(a)));
        exp_s.push_back((j == 0) ? 1 : 0);
        ph = (ph + sp * W0[j] + sc * W1[j] + sn * W2[j]) & 255;
      end
    end
  endtask

  always @(posedge clk) en_s = en;

  always @(negedge clk) begin
    if (!resetn) begin
      prev_v = 1'b0;
    end else if (en_s) begin
      if (sample_valid) begin
        nvalid++;
        if (symbol_clk) npulse++;
        cap_i.push_back(int'(i_data));
        cap_q.push_back(int'(q_data));
        chk("busy_run", busy, 1);
        if (exp_i.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_sample: got i=%0d q=%0d want none", i_data, q_data);
        end else begin
          chk("i_data", i_data, exp_i.pop_front());
          chk("q_data", q_data, exp_q.pop_front());
          chk("symbol_clk", symbol_clk, exp_s.pop_front());
        end
      end else begin
        chk("idle_i", i_data, 0);
        chk("idle_q", q_data, 0);
        chk("idle_sc", symbol_clk, 0);
        if (prev_v) chk("busy_fall", busy, 0);
      end
      prev_v = sample_valid;
    end
  end

  task automatic send(input bit b[$], input bit mark_last,
                      input bit toggle, input int stop_at);
    int k;
    bit ph;
    bit seen;
    bit acc;
    k = 0;
    ph = 1'b1;
    seen = 1'b0;
    exp_i.delete();
    exp_q.delete();
    exp_s.delete();
    cap_i.delete();
    cap_q.delete();
    nvalid = 0;
    npulse = 0;
    model(b);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      #1;
      if (busy) seen = 1'b1;
      if (stop_at >= 0 && nvalid >= stop_at) return;
      if (k == b.size() && seen && !busy) begin
        chk("leftover", exp_i.size(), 0);
        return;
      end
      en = toggle ? ph : 1'b1;
      ph = ~ph;
      bit_valid = (k < b.size());
      bit_data = bit_valid ? b[k] : 1'b0;
      bit_last = mark_last && (k == b.size() - 1);
      #1;
      acc = en && bit_valid && bit_ready;
      @(posedge clk);
      if (acc) k++;
    end
    total++;
    bad++;
    $display("FAIL timeout: got k=%0d busy=%0d want packet done", k, busy);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bit_ready, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_i", i_data, 0);
    chk("rst_q", q_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("idle_ready", bit_ready, 1);

    pk = '{1, 1, 1, 1};
    send(pk, 1'b1, 1'b0, -1);
    chk("ones_count", nvalid, 64);
    chk("ones_pulses", npulse, 4);
    chk("ones_s0_i", cap_i[0], 7);
    chk("ones_s0_q", cap_q[0], 0);
    chk("ones_s16_i", cap_i[16], 0);
    chk("ones_s16_q", cap_q[16], 7);
    chk("ones_s63_i", cap_i[63], 7);
    chk("ones_s63_q", cap_q[63], -1);
    chk("ones_underrun", underrun, 0);

    pk = '{0, 0, 0, 0};
    send(pk, 1'b1, 1'b0, -1);
    chk("zeros_count", nvalid, 64);
    chk("zeros_s1_q", cap_q[1], -1);
    chk("zeros_s16_i", cap_i[16], 0);
    chk("zeros_s16_q", cap_q[16], -7);

    pk = '{1, 0, 1, 0};
    send(pk, 1'b1, 1'b0, -1);
    chk("alt_count", nvalid, 64);
    chk("alt_pulses", npulse, 4);
    chk("alt_s16_i", cap_i[16], 1);
    chk("alt_s16_q", cap_q[16], 7);

    pk = '{1, 1};
    send(pk, 1'b0, 1'b0, -1);
    chk("urun_count", nvalid, 32);
    chk("urun_pulses", npulse, 2);
    chk("urun_flag", underrun, 1);

    pk = '{1, 1, 1, 1};
    send(pk, 1'b1, 1'b1, -1);
    chk("tog_count", nvalid, 64);
    chk("tog_s16_q", cap_q[16], 7);
    chk("tog_underrun", underrun, 0);

    send(pk, 1'b1, 1'b0, 20);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_i", i_data, 0);
    chk("mid_rst_q", q_data, 0);
    chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_sc", symbol_clk, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", bit_ready, 0);
    bit_valid = 1'b0;
    bit_last = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    send(pk, 1'b1, 1'b0, -1);
    chk("post_rst_count", nvalid, 64);
    chk("post_rst_s0_i", cap_i[0], 7);
    chk("post_rst_s0_q", cap_q[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
